// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Main control FSM for a multicycle MIPS datapath. It steps each
//            instruction through fetch/decode/execute/memory/writeback,
//            waits on a ready handshake from unified memory, guards those
//            waits with a watchdog and flags unsupported opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       iorD,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluop,
  output logic [1:0] pcSrc,
  output logic       pcWrite,
  output logic       branch,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // The watchdog fires on the cycle the counter reaches MEM_TIMEOUT-1,
  // i.e. on the MEM_TIMEOUT-th consecutive not-ready cycle.
  localparam bit         c_wd_enable  = (MEM_TIMEOUT != 0);
  localparam logic [7:0] c_wd_last    = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  state_t     w_next;
  logic [7:0] w_next_cnt;
  logic       w_waiting;
  logic       w_expire;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_illegal;

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_next_cnt;
    end
  end

  // Next-state, control outputs and watchdog, all decoded from the current state.
  always_comb begin
    w_next      = r_state;
    w_waiting   = 1'b0;
    w_expire    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    iorD        = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluop       = 2'b00;
    pcSrc       = 2'b00;

    case (r_state)
      S_FETCH: begin
        aluSrcB    = 2'b01;
        w_waiting  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        if (opcode == c_op_rtype)                      w_next = S_EXECUTE;
        else if (opcode == c_op_lw || opcode == c_op_sw) w_next = S_MEMADR;
        else if (opcode == c_op_beq)                   w_next = S_BRANCH;
        else if (ENABLE_ADDI && opcode == c_op_addi)   w_next = S_ADDIEXEC;
        else if (ENABLE_JUMP && opcode == c_op_j)      w_next = S_JUMP;
        else begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = (opcode == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iorD      = 1'b1;
        w_waiting = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memToReg    = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        iorD        = 1'b1;
        w_mem_write = 1'b1;
        w_waiting   = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regDst      = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA  = 1'b1;
        aluop    = 2'b01;
        pcSrc    = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_ADDIEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pcSrc      = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    // A ready in the same cycle always wins over the watchdog.
    if (c_wd_enable && w_waiting && !mem_ready && (r_wait_cnt == c_wd_last)) begin
      w_expire    = 1'b1;
      w_next      = S_FETCH;
      w_ir_write  = 1'b0;
      w_pc_write  = 1'b0;
      w_reg_write = 1'b0;
    end

    if (w_expire || (w_next != r_state)) w_next_cnt = 8'd0;
    else if (w_waiting && !mem_ready)    w_next_cnt = r_wait_cnt + 8'd1;
    else                                 w_next_cnt = r_wait_cnt;
  end

  // Side-effecting strobes are suppressed for as long as reset is held.
  assign irWrite     = w_ir_write  & ~reset;
  assign pcWrite     = w_pc_write  & ~reset;
  assign memWrite    = w_mem_write & ~reset;
  assign regWrite    = w_reg_write & ~reset;
  assign branch      = w_branch    & ~reset;
  assign illegal_op  = w_illegal   & ~reset;
  assign mem_timeout = w_expire    & ~reset;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed self-checking bench for multicycle_control_unit. One
//            instance uses default parameters, a second has jumps disabled
//            and a 4-cycle memory watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       reset_a, rdy_a;
  logic [5:0] op_a;
  logic       iorD_a, irWrite_a, memWrite_a, regDst_a, memToReg_a, regWrite_a, aluSrcA_a;
  logic [1:0] aluSrcB_a, aluop_a, pcSrc_a;
  logic       pcWrite_a, branch_a, illegal_a, tmo_a;
  logic [3:0] state_a;

  // Instance B: ENABLE_JUMP=0, MEM_TIMEOUT=4
  logic       reset_b, rdy_b;
  logic [5:0] op_b;
  logic       iorD_b, irWrite_b, memWrite_b, regDst_b, memToReg_b, regWrite_b, aluSrcA_b;
  logic [1:0] aluSrcB_b, aluop_b, pcSrc_b;
  logic       pcWrite_b, branch_b, illegal_b, tmo_b;
  logic [3:0] state_b;

  multicycle_control_unit u_dut_a (
    .clk(clk), .reset(reset_a), .opcode(op_a), .mem_ready(rdy_a),
    .iorD(iorD_a), .irWrite(irWrite_a), .memWrite(memWrite_a), .regDst(regDst_a),
    .memToReg(memToReg_a), .regWrite(regWrite_a), .aluSrcA(aluSrcA_a),
    .aluSrcB(aluSrcB_a), .aluop(aluop_a), .pcSrc(pcSrc_a), .pcWrite(pcWrite_a),
    .branch(branch_a), .illegal_op(illegal_a), .mem_timeout(tmo_a), .state(state_a)
  );

  multicycle_control_unit #(.ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b0), .MEM_TIMEOUT(4)) u_dut_b (
    .clk(clk), .reset(reset_b), .opcode(op_b), .mem_ready(rdy_b),
    .iorD(iorD_b), .irWrite(irWrite_b), .memWrite(memWrite_b), .regDst(regDst_b),
    .memToReg(memToReg_b), .regWrite(regWrite_b), .aluSrcA(aluSrcA_b),
    .aluSrcB(aluSrcB_b), .aluop(aluop_b), .pcSrc(pcSrc_b), .pcWrite(pcWrite_b),
    .branch(branch_b), .illegal_op(illegal_b), .mem_timeout(tmo_b), .state(state_b)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; new outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1; rdy_a = 1'b1; op_a = 6'b000000;
    reset_b = 1'b1; rdy_b = 1'b1; op_b = 6'b000000;

    // ---------------- reset behaviour (instance A) ----------------
    tick();
    chk("rst_irWrite_forced0", {7'd0, irWrite_a}, 8'd0);
    chk("rst_pcWrite_forced0", {7'd0, pcWrite_a}, 8'd0);
    tick();
    chk("rst_state", {4'd0, state_a}, 8'd0);
    chk("rst_aluSrcB", {6'd0, aluSrcB_a}, 8'd1);
    reset_a = 1'b0;
    #1;
    chk("post_rst_irWrite", {7'd0, irWrite_a}, 8'd1);
    chk("post_rst_pcWrite", {7'd0, pcWrite_a}, 8'd1);

    // ---------------- lw, zero wait ----------------
    op_a = 6'b100011;
    tick(); chk("lw_s1", {4'd0, state_a}, 8'd1);
    chk("lw_dec_aluSrcB", {6'd0, aluSrcB_a}, 8'd3);
    tick(); chk("lw_s2", {4'd0, state_a}, 8'd2);
    chk("lw_adr_alu", {5'd0, aluSrcA_a, aluSrcB_a}, 8'b110);
    tick(); chk("lw_s3", {4'd0, state_a}, 8'd3);
    chk("lw_read_iorD", {7'd0, iorD_a}, 8'd1);
    tick(); chk("lw_s4", {4'd0, state_a}, 8'd4);
    chk("lw_wb_ctl", {5'd0, memToReg_a, regWrite_a, regDst_a}, 8'b110);
    tick(); chk("lw_back_fetch", {4'd0, state_a}, 8'd0);

    // ---------------- sw with 3 not-ready cycles ----------------
    op_a = 6'b101011;
    tick(); chk("sw_s1", {4'd0, state_a}, 8'd1);
    tick(); chk("sw_s2", {4'd0, state_a}, 8'd2);
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_wait_state", {4'd0, state_a}, 8'd5);
      chk("sw_wait_ctl", {6'd0, memWrite_a, iorD_a}, 8'b11);
    end
    rdy_a = 1'b1;
    #1;
    chk("sw_last_ctl", {5'd0, memWrite_a, iorD_a, tmo_a}, 8'b110);
    tick(); chk("sw_back_fetch", {4'd0, state_a}, 8'd0);

    // ---------------- R-type ----------------
    op_a = 6'b000000;
    tick(); chk("r_s1", {4'd0, state_a}, 8'd1);
    tick(); chk("r_s6", {4'd0, state_a}, 8'd6);
    chk("r_exec_ctl", {5'd0, aluSrcA_a, aluop_a}, 8'b110);
    tick(); chk("r_s7", {4'd0, state_a}, 8'd7);
    chk("r_wb_ctl", {6'd0, regDst_a, regWrite_a}, 8'b11);
    tick(); chk("r_back_fetch", {4'd0, state_a}, 8'd0);

    // ---------------- beq ----------------
    op_a = 6'b000100;
    tick(); chk("beq_s1", {4'd0, state_a}, 8'd1);
    tick(); chk("beq_s8", {4'd0, state_a}, 8'd8);
    chk("beq_ctl", {2'd0, aluSrcA_a, aluop_a, pcSrc_a, branch_a}, 8'b1_01_01_1);
    tick(); chk("beq_back_fetch", {4'd0, state_a}, 8'd0);

    // ---------------- addi ----------------
    op_a = 6'b001000;
    tick(); chk("addi_s1", {4'd0, state_a}, 8'd1);
    tick(); chk("addi_s9", {4'd0, state_a}, 8'd9);
    chk("addi_exec_ctl", {5'd0, aluSrcA_a, aluSrcB_a}, 8'b110);
    tick(); chk("addi_s10", {4'd0, state_a}, 8'd10);
    chk("addi_wb_ctl", {6'd0, regWrite_a, regDst_a}, 8'b10);
    tick(); chk("addi_back_fetch", {4'd0, state_a}, 8'd0);

    // ---------------- j ----------------
    op_a = 6'b000010;
    tick(); chk("j_s1", {4'd0, state_a}, 8'd1);
    tick(); chk("j_s11", {4'd0, state_a}, 8'd11);
    chk("j_ctl", {5'd0, pcSrc_a, pcWrite_a}, 8'b101);
    tick(); chk("j_back_fetch", {4'd0, state_a}, 8'd0);

    // ---------------- illegal 111111 ----------------
    op_a = 6'b111111;
    tick(); chk("ill_s1", {4'd0, state_a}, 8'd1);
    chk("ill_pulse", {4'd0, illegal_a, regWrite_a, pcWrite_a, memWrite_a}, 8'b1000);
    tick(); chk("ill_back_fetch", {4'd0, state_a}, 8'd0);
    chk("ill_pulse_gone", {7'd0, illegal_a}, 8'd0);

    // ---------------- reset mid-instruction ----------------
    op_a = 6'b000000;
    tick(); tick(); tick();
    chk("midrst_in_aluwb", {4'd0, state_a}, 8'd7);
    reset_a = 1'b1;
    #1;
    chk("midrst_regWrite_forced0", {7'd0, regWrite_a}, 8'd0);
    tick(); chk("midrst_state", {4'd0, state_a}, 8'd0);
    reset_a = 1'b0;

    // ---------------- instance B: j disabled ----------------
    reset_b = 1'b0;
    op_b = 6'b000010;
    #1;
    tick(); chk("b_j_s1", {4'd0, state_b}, 8'd1);
    chk("b_j_illegal", {6'd0, illegal_b, pcWrite_b}, 8'b10);
    tick(); chk("b_j_back_fetch", {4'd0, state_b}, 8'd0);

    // ---------------- instance B: MEMREAD timeout ----------------
    op_b = 6'b100011;
    tick(); tick(); chk("b_to_s2", {4'd0, state_b}, 8'd2);
    rdy_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_to_wait_state", {4'd0, state_b}, 8'd3);
      chk("b_to_no_timeout_yet", {7'd0, tmo_b}, 8'd0);
    end
    tick();
    chk("b_to_fire", {6'd0, tmo_b, regWrite_b}, 8'b10);
    rdy_b = 1'b1;
    #1;
    chk("b_to_ready_cancels", {7'd0, tmo_b}, 8'd0);
    rdy_b = 1'b0;
    #1;
    tick(); chk("b_to_back_fetch", {4'd0, state_b}, 8'd0);
    chk("b_to_pulse_gone", {7'd0, tmo_b}, 8'd0);

    // ---------------- instance B: ready on 4th cycle wins ----------------
    rdy_b = 1'b1;
    #1;
    tick(); tick(); chk("b_rdy_s2", {4'd0, state_b}, 8'd2);
    rdy_b = 1'b0;
    tick(); tick(); tick(); tick();
    chk("b_rdy_4th_state", {4'd0, state_b}, 8'd3);
    rdy_b = 1'b1;
    #1;
    chk("b_rdy_no_timeout", {7'd0, tmo_b}, 8'd0);
    tick(); chk("b_rdy_to_memwb", {4'd0, state_b}, 8'd4);

    // ---------------- instance B: FETCH timeout ----------------
    tick(); chk("b_f_fetch", {4'd0, state_b}, 8'd0);
    rdy_b = 1'b0;
    #1;
    tick(); tick(); tick();
    chk("b_f_4th_timeout", {5'd0, tmo_b, irWrite_b, pcWrite_b}, 8'b100);
    tick(); chk("b_f_stays_fetch", {4'd0, state_b}, 8'd0);
    chk("b_f_counter_cleared", {7'd0, tmo_b}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
